// File: rtl/fft_mag_framer_pkg.sv
// Shared types and default sizing for the FFT magnitude framer
// and its downstream peak-detect consumer.
package fft_mag_framer_pkg;

  localparam int FFT_SIZE_DEF    = 2048;
  localparam int INDEX_WIDTH_DEF = 11;
  localparam int IN_WIDTH_DEF    = 16;
  localparam int WIDTH_DEF       = 32;
  localparam int GAP_CYCLES_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  // A frame is well formed only when in_last and the
  // final-bin position agree; any disagreement is an error.
  function automatic logic len_mismatch(
    input logic last,
    input logic at_end
  );
    return last ^ at_end;
  endfunction

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage re^2 + im^2 pipeline with valid, bin index and
// length-error sideband carried alongside the data.
// Ports: clk, reset_n, in_valid/re/im/index/err in,
//        busy, valid, mag, index_out, err_out out.
module mag_sq_pipe #(
  parameter int IN_WIDTH    = 16,
  parameter int WIDTH       = 32,
  parameter int INDEX_WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic signed [IN_WIDTH-1:0] re,
  input  logic signed [IN_WIDTH-1:0] im,
  input  logic [INDEX_WIDTH-1:0]     index,
  input  logic                       err,
  output logic                       busy,
  output logic                       valid,
  output logic [WIDTH-1:0]           mag,
  output logic [INDEX_WIDTH-1:0]     index_out,
  output logic                       err_out
);

  logic signed [WIDTH-1:0] re_x;
  logic signed [WIDTH-1:0] im_x;
  logic signed [WIDTH-1:0] re_sq;
  logic signed [WIDTH-1:0] im_sq;

  logic                   s1_valid;
  logic [WIDTH-1:0]       s1_re_sq;
  logic [WIDTH-1:0]       s1_im_sq;
  logic [INDEX_WIDTH-1:0] s1_index;
  logic                   s1_err;

  // Squares are formed at full output width so that
  // (-2^(N-1))^2 is exact; the sum of two such squares
  // still fits the unsigned result without wrapping.
  assign re_x = {{(WIDTH-IN_WIDTH){re[IN_WIDTH-1]}}, re};
  assign im_x = {{(WIDTH-IN_WIDTH){im[IN_WIDTH-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
      s1_index <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_err   <= in_valid & err;
      if (in_valid) begin
        s1_re_sq <= re_sq;
        s1_im_sq <= im_sq;
        s1_index <= index;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid     <= 1'b0;
      mag       <= '0;
      index_out <= '0;
      err_out   <= 1'b0;
    end else begin
      valid   <= s1_valid;
      err_out <= s1_valid & s1_err;
      if (s1_valid) begin
        mag       <= s1_re_sq + s1_im_sq;
        index_out <= s1_index;
      end
    end
  end

  assign busy = s1_valid | valid;

endmodule

// File: rtl/fft_mag_framer.sv
// Frames a stream of complex FFT bins and emits |X|^2 per bin.
// Ports: clk, reset_n, in_re/in_im/in_valid/in_last/in_ready,
//        frame_start, mag_out, mag_valid, bin_index, len_err.
module fft_mag_framer
  import fft_mag_framer_pkg::*;
#(
  parameter int FFT_SIZE    = FFT_SIZE_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int IN_WIDTH    = IN_WIDTH_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [IN_WIDTH-1:0] in_re,
  input  logic signed [IN_WIDTH-1:0] in_im,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       frame_start,
  output logic [WIDTH-1:0]           mag_out,
  output logic                       mag_valid,
  output logic [INDEX_WIDTH-1:0]     bin_index,
  output logic                       len_err
);

  localparam int GW = $clog2(GAP_CYCLES + 2);

  state_t state;
  state_t state_nxt;

  logic [INDEX_WIDTH-1:0] cnt;
  logic [GW-1:0]          gap_cnt;

  logic xfer;
  logic at_end;
  logic frame_end;
  logic err_in;
  logic busy;
  logic gap_done;

  assign xfer      = in_valid & in_ready;
  assign at_end    = (cnt == INDEX_WIDTH'(FFT_SIZE - 1));
  assign frame_end = xfer & (at_end | in_last);
  assign err_in    = len_mismatch(in_last, at_end);

  // Leave DRAIN only once the pipeline is empty and a
  // further GAP_CYCLES idle cycles have elapsed, so the
  // next frame_start always trails the last beat.
  assign gap_done = !busy &&
                    (gap_cnt == GW'(GAP_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (in_valid) state_nxt = ST_START;
      ST_START:  state_nxt = ST_STREAM;
      ST_STREAM: if (frame_end) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (gap_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    frame_start = 1'b0;
    unique case (1'b1)
      (state == ST_START):  frame_start = 1'b1;
      (state == ST_STREAM): in_ready    = 1'b1;
      default: ;
    endcase
  end

  // The final bin of a frame does not advance the counter,
  // so bin_index never wraps inside a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == ST_START) begin
      cnt <= '0;
    end else if (xfer && !frame_end) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (state != ST_DRAIN) begin
      gap_cnt <= '0;
    end else if (!busy && !gap_done) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  mag_sq_pipe #(
    .IN_WIDTH    (IN_WIDTH),
    .WIDTH       (WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (xfer),
    .re        (in_re),
    .im        (in_im),
    .index     (cnt),
    .err       (err_in),
    .busy      (busy),
    .valid     (mag_valid),
    .mag       (mag_out),
    .index_out (bin_index),
    .err_out   (len_err)
  );

endmodule

// File: tb/tb_fft_mag_framer.sv
// Bench for fft_mag_framer: behavioural expected-beat queue
// plus hand-computed literal checks on directed frames.
module tb_fft_mag_framer;

  localparam int N   = 8;
  localparam int IXW = 3;
  localparam int INW = 16;
  localparam int W   = 32;
  localparam int GAP = 2;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic signed [INW-1:0] in_re = '0;
  logic signed [INW-1:0] in_im = '0;
  logic                  in_valid = 1'b0;
  logic                  in_last = 1'b0;
  logic                  in_ready;
  logic                  frame_start;
  logic [W-1:0]          mag_out;
  logic                  mag_valid;
  logic [IXW-1:0]        bin_index;
  logic                  len_err;

  always #5 clk = ~clk;

  fft_mag_framer #(
    .FFT_SIZE    (N),
    .INDEX_WIDTH (IXW),
    .IN_WIDTH    (INW),
    .WIDTH       (W),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_re       (in_re),
    .in_im       (in_im),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .mag_out     (mag_out),
    .mag_valid   (mag_valid),
    .bin_index   (bin_index),
    .len_err     (len_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int           due;
    logic [W-1:0] mag;
    int           idx;
    bit           err;
  } beat_t;

  beat_t exq[$];
  int    pos = 0;

  int beats_total = 0;
  int errs_total = 0;
  int fs_total = 0;
  int last_err_idx = -1;
  int last_mv = 0;
  bit have_mv = 1'b0;
  int fs_cyc = 0;
  bit first_after_fs = 1'b0;
  int lat = -1;

  logic [W-1:0] obs_mag[$];
  int           obs_idx[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model and compare: a transfer in cycle T must show up
  // as one beat in cycle T+2 carrying its in-frame position.
  always @(negedge clk) begin
    bit           exp_now;
    beat_t        b;
    longint       r;
    longint       i;
    bit           fend;
    cyc++;
    if (!reset_n) begin
      chk("reset_outputs",
          {58'd0, in_ready, frame_start, mag_valid,
           len_err, |mag_out, |bin_index}, 64'd0);
      exq.delete();
      pos = 0;
      have_mv = 1'b0;
      first_after_fs = 1'b0;
    end else begin
      exp_now = (exq.size() > 0) && (exq[0].due == cyc);
      chk("mag_valid", mag_valid, exp_now);
      chk("fs_overlap", frame_start & mag_valid, 0);
      if (exp_now) begin
        b = exq.pop_front();
        chk("mag_out", mag_out, b.mag);
        chk("bin_index", bin_index, b.idx);
        chk("len_err", len_err, b.err);
      end else begin
        chk("len_err_idle", len_err, 0);
      end
      if (mag_valid) begin
        beats_total++;
        obs_mag.push_back(mag_out);
        obs_idx.push_back(int'(bin_index));
        if (len_err) begin
          errs_total++;
          last_err_idx = int'(bin_index);
        end
        if (first_after_fs) lat = cyc - fs_cyc;
        first_after_fs = 1'b0;
        last_mv = cyc;
        have_mv = 1'b1;
      end
      if (frame_start) begin
        fs_total++;
        if (have_mv)
          chk("fs_gap", (cyc - last_mv) >= 2 + GAP, 1);
        fs_cyc = cyc;
        first_after_fs = 1'b1;
      end
      if (in_valid && in_ready) begin
        r = longint'(in_re);
        i = longint'(in_im);
        b.due = cyc + 2;
        b.mag = W'(r * r + i * i);
        b.idx = pos;
        b.err = in_last ? (pos != N - 1) : (pos == N - 1);
        exq.push_back(b);
        fend = in_last || (pos == N - 1);
        pos = fend ? 0 : pos + 1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bin i carries (re0 + i*dre, im0 + i*dim); in_last on
  // bin last_at; toggle inserts an idle cycle after each bin.
  task automatic send(input int n,
                      input int re0, input int im0,
                      input int dre, input int dim,
                      input int last_at,
                      input bit toggle);
    int t;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_re    = INW'(re0 + k * dre);
      in_im    = INW'(im0 + k * dim);
      in_last  = (k == last_at);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 200);
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: bin %0d", k);
        return;
      end
      @(posedge clk);
      #1;
      if (toggle) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drop();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  int b0, f0, e0, m0;

  task automatic mark();
    b0 = beats_total;
    f0 = fs_total;
    e0 = errs_total;
    m0 = obs_mag.size();
  endtask

  initial begin
    idle(3);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mag_valid", mag_valid, 0);
    chk("rst_mag_out", mag_out, 0);
    reset_n = 1'b1;
    idle(2);

    // ramp frame: bin k = (k, 0)
    mark();
    send(8, 0, 0, 1, 0, 7, 1'b0);
    drop();
    idle(12);
    chk("t1_frames", fs_total - f0, 1);
    chk("t1_beats", beats_total - b0, 8);
    chk("t1_errs", errs_total - e0, 0);
    chk("t1_latency", lat, 3);
    if (obs_mag.size() >= m0 + 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t1_mag", obs_mag[m0 + k], k * k);
        chk("t1_idx", obs_idx[m0 + k], k);
      end
    end

    // most negative corner, single-bin frame
    mark();
    send(1, -32768, -32768, 0, 0, 0, 1'b0);
    drop();
    idle(12);
    chk("t2_beats", beats_total - b0, 1);
    chk("t2_errs", errs_total - e0, 1);
    if (obs_mag.size() > m0)
      chk("t2_mag", obs_mag[m0], 32'h8000_0000);

    // early in_last at bin 4, next frame queued behind it
    mark();
    send(5, 10, -3, 7, 5, 4, 1'b0);
    send(8, -100, 50, 33, -21, 7, 1'b0);
    drop();
    idle(12);
    chk("t3_frames", fs_total - f0, 2);
    chk("t3_beats", beats_total - b0, 13);
    chk("t3_errs", errs_total - e0, 1);
    chk("t3_err_idx", last_err_idx, 4);
    if (obs_mag.size() >= m0 + 6) begin
      chk("t3_mag0", obs_mag[m0], 109);
      chk("t3_mag4", obs_mag[m0 + 4], 1733);
      chk("t3_next_idx", obs_idx[m0 + 5], 0);
    end

    // in_valid toggling every cycle
    mark();
    send(8, 1, 1, 2, -1, 7, 1'b1);
    drop();
    idle(12);
    chk("t4_beats", beats_total - b0, 8);
    chk("t4_errs", errs_total - e0, 0);
    if (obs_mag.size() >= m0 + 8) begin
      for (int k = 0; k < 8; k++)
        chk("t4_idx", obs_idx[m0 + k], k);
      chk("t4_mag7", obs_mag[m0 + 7], 261);
    end

    // back-to-back frames, in_last never asserted
    mark();
    send(16, -50, 20, 3, -2, -1, 1'b0);
    drop();
    idle(12);
    chk("t5_frames", fs_total - f0, 2);
    chk("t5_beats", beats_total - b0, 16);
    chk("t5_errs", errs_total - e0, 2);
    chk("t5_err_idx", last_err_idx, 7);
    if (obs_idx.size() >= m0 + 9) begin
      chk("t5_idx7", obs_idx[m0 + 7], 7);
      chk("t5_idx8", obs_idx[m0 + 8], 0);
    end

    // reset while bin 3 is presented
    send(3, 5, 5, 1, 1, -1, 1'b0);
    in_re = 16'sd8;
    in_im = 16'sd8;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_mag_valid", mag_valid, 0);
    chk("t6_rst_mag_out", mag_out, 0);
    chk("t6_rst_bin_index", bin_index, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_frame_start", frame_start, 0);
    chk("t6_rst_len_err", len_err, 0);
    drop();
    idle(2);
    mark();
    reset_n = 1'b1;
    idle(4);
    chk("t6_quiet_after_release", beats_total - b0, 0);
    send(8, 3, -3, 1, 1, 7, 1'b0);
    drop();
    idle(12);
    chk("t6_frames", fs_total - f0, 1);
    chk("t6_beats", beats_total - b0, 8);
    chk("t6_latency", lat, 3);
    if (obs_idx.size() > m0)
      chk("t6_first_idx", obs_idx[m0], 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end

endmodule
